// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM with registered read.
// Presents a first-word-fall-through pop interface by prefetching the head word.
module dp_ram_fifo_ctrl #(
  parameter int ram_width = 8,
  parameter int addr_size = 4,
  parameter int ram_depth = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [ram_width-1:0] push_data,
  output logic                 full,
  output logic                 pop_valid,
  input  logic                 pop_ready,
  output logic [ram_width-1:0] pop_data,
  output logic [addr_size:0]   level,
  output logic                 ram_write_en,
  output logic [addr_size-1:0] ram_wr_addr,
  output logic [ram_width-1:0] ram_data_in,
  output logic                 ram_read_en,
  output logic [addr_size-1:0] ram_rd_addr,
  input  logic [ram_width-1:0] ram_data_out
);

  localparam logic [addr_size-1:0] last_addr = addr_size'(ram_depth - 1);
  localparam logic [addr_size:0]   depth_cnt = (addr_size + 1)'(ram_depth);

  logic [addr_size-1:0] wr_ptr;
  logic [addr_size-1:0] rd_ptr;
  logic [addr_size:0]   mem_count;
  logic                 pop_valid_q;
  logic                 push_ok;
  logic                 rd_issue;

  // Pop handshake: a word moves when pop_valid & pop_ready on a rising edge.
  // pop_data must stay stable while pop_valid & !pop_ready; holding off
  // read issue keeps the RAM output register frozen in that case.
  assign full      = (mem_count == depth_cnt);
  assign push_ok   = push & ~full & ~reset;
  assign rd_issue  = (mem_count != '0) & (~pop_valid_q | pop_ready) & ~reset;

  assign ram_write_en = push_ok;
  assign ram_wr_addr  = wr_ptr;
  assign ram_data_in  = push_data;
  assign ram_read_en  = rd_issue;
  assign ram_rd_addr  = rd_ptr;

  assign pop_valid = pop_valid_q;
  assign pop_data  = ram_data_out;
  assign level     = mem_count + {{addr_size{1'b0}}, pop_valid_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_count   <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= (wr_ptr == last_addr) ? '0 : wr_ptr + 1'b1;
      if (rd_issue)
        rd_ptr <= (rd_ptr == last_addr) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, rd_issue})
        2'b10:   mem_count <= mem_count + 1'b1;
        2'b01:   mem_count <= mem_count - 1'b1;
        default: mem_count <= mem_count;
      endcase
      if (rd_issue)
        pop_valid_q <= 1'b1;
      else if (pop_ready)
        pop_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Bench for dp_ram_fifo_ctrl with a behavioural dual-port RAM beside it.
// Directed pushes feed an expected queue; a monitor checks every popped word.
module tb_dp_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic [7:0] push_data = '0;
  logic       pop_ready = 1'b0;
  logic       full;
  logic       pop_valid;
  logic [7:0] pop_data;
  logic [4:0] level;
  logic       ram_write_en;
  logic [3:0] ram_wr_addr;
  logic [7:0] ram_data_in;
  logic       ram_read_en;
  logic [3:0] ram_rd_addr;
  logic [7:0] ram_data_out;

  logic [7:0] mem [16];
  logic [7:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  dp_ram_fifo_ctrl #(.ram_width(8), .addr_size(4), .ram_depth(16)) dut (
    .clk(clk), .reset(reset), .push(push), .push_data(push_data),
    .full(full), .pop_valid(pop_valid), .pop_ready(pop_ready),
    .pop_data(pop_data), .level(level),
    .ram_write_en(ram_write_en), .ram_wr_addr(ram_wr_addr),
    .ram_data_in(ram_data_in), .ram_read_en(ram_read_en),
    .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out)
  );

  // External RAM: registered read, synchronous reset of the output register.
  always @(posedge clk) begin
    if (reset) begin
      ram_data_out <= '0;
    end else begin
      if (ram_write_en) mem[ram_wr_addr] <= ram_data_in;
      if (ram_read_en) ram_data_out <= mem[ram_rd_addr];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a transfer happens on the next edge when valid & ready.
  always @(negedge clk) begin
    if (!reset && pop_valid && pop_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", {24'h0, pop_data}, 32'hdead);
      end else begin
        check("pop_data", {24'h0, pop_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver ----------------
  // Inputs change 2 units after the rising edge; the task returns at the
  // falling edge of the same cycle, where checks sample settled outputs.
  task automatic cyc(input logic r, input logic p, input logic [7:0] d, input logic rdy);
    @(posedge clk);
    #2;
    reset = r;
    push = p;
    push_data = d;
    pop_ready = rdy;
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    // Reset then idle
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("rst_full", full, 0);
    check("rst_pop_valid", pop_valid, 0);
    check("rst_level", level, 0);
    check("rst_write_en", ram_write_en, 0);
    check("rst_read_en", ram_read_en, 0);
    check("rst_wr_addr", ram_wr_addr, 0);
    check("rst_rd_addr", ram_rd_addr, 0);
    check("rst_pop_data", pop_data, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      check("idle_pop_valid", pop_valid, 0);
    end

    // Single word, 2-cycle latency
    cyc(1'b0, 1'b1, 8'hA5, 1'b0);
    exp_q.push_back(8'hA5);
    check("single_write_en", ram_write_en, 1);
    check("single_wr_addr", ram_wr_addr, 0);
    check("single_data_in", ram_data_in, 8'hA5);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("single_read_en", ram_read_en, 1);
    check("single_rd_addr", ram_rd_addr, 0);
    check("single_level_c1", level, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("single_pop_valid", pop_valid, 1);
    check("single_level_c2", level, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("single_level_done", level, 0);
    check("single_valid_done", pop_valid, 0);

    // Fill and overflow with consumer stalled
    for (int k = 0; k < 17; k++) begin
      cyc(1'b0, 1'b1, 8'(k), 1'b0);
      exp_q.push_back(8'(k));
      check("fill_write_en", ram_write_en, 1);
      if (k == 16) begin
        check("fill_level16", level, 16);
        check("fill_not_full", full, 0);
      end
    end
    cyc(1'b0, 1'b1, 8'hFF, 1'b0);
    check("ovf_level17", level, 17);
    check("ovf_full", full, 1);
    check("ovf_write_en", ram_write_en, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("drain_start_full", full, 1);
    check("drain_start_read", ram_read_en, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("drain_full_clear", full, 0);
    check("drain_level", level, 16);
    drain(40);

    // Backpressure stall holding 0x11 at the head with 0x22 queued in RAM
    cyc(1'b0, 1'b1, 8'h11, 1'b0);
    exp_q.push_back(8'h11);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h22, 1'b0);
    exp_q.push_back(8'h22);
    check("stall_head_valid", pop_valid, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      check("stall_pop_data", pop_data, 8'h11);
      check("stall_read_en", ram_read_en, 0);
      check("stall_level", level, 2);
    end
    drain(10);

    // Wrap-around streaming at full throughput
    for (int c = 0; c < 42; c++) begin
      if (c < 40) begin
        cyc(1'b0, 1'b1, 8'(c), 1'b1);
        exp_q.push_back(8'(c));
      end else begin
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
      end
      if (c >= 2) check("stream_valid", pop_valid, 1);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("stream_done_valid", pop_valid, 0);
    check("stream_queue_empty", exp_q.size(), 0);

    // Reset mid-operation at level 9
    for (int k = 0; k < 9; k++) cyc(1'b0, 1'b1, 8'h50 + 8'(k), 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("mid_level9", level, 9);
    cyc(1'b1, 1'b1, 8'h77, 1'b0);
    check("mid_rst_write_en", ram_write_en, 0);
    check("mid_rst_read_en", ram_read_en, 0);
    cyc(1'b0, 1'b1, 8'h3C, 1'b0);
    exp_q.push_back(8'h3C);
    check("mid_level0", level, 0);
    check("mid_pop_valid0", pop_valid, 0);
    check("mid_full0", full, 0);
    check("mid_pop_data0", pop_data, 0);
    check("mid_wr_addr", ram_wr_addr, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("mid_rd_addr", ram_rd_addr, 0);
    check("mid_read_en", ram_read_en, 1);
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
